// File: rtl/pic_gpio_bank.sv
// pic_gpio_bank: WIDTH-bit memory-mapped GPIO bank.
// It provides output data and output-enable registers, atomic set/clear/toggle,
// synchronised inputs, and per-pin rising/falling edge capture into a W1C
// status register that drives a single irq line.
module pic_gpio_bank #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      address,
  input  logic [31:0]      data_in,
  input  logic             wen,
  input  logic             ren,
  output logic [31:0]      data_out,
  output logic             ready,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    R_OUT      = 4'd0,
    R_OE       = 4'd1,
    R_IN       = 4'd2,
    R_SET      = 4'd3,
    R_CLR      = 4'd4,
    R_TGL      = 4'd5,
    R_RISE_EN  = 4'd6,
    R_FALL_EN  = 4'd7,
    R_IRQ_STAT = 4'd8
  } reg_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  logic [3:0]       reg_sel;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] evt_w;
  logic [WIDTH-1:0] w1c_w;
  logic [31:0]      rd_word;

  // Address bits outside [5:2] and data bits above WIDTH are don't-care.
  logic unused_bits;
  assign unused_bits = ^{address, data_in};

  // Access decode: an access happens only on the accepting edge in IDLE; write wins over read.
  always_comb begin
    reg_sel = address[5:2];
    wdata   = data_in[WIDTH-1:0];
    wr_acc  = (state_q == S_IDLE) && wen;
    rd_acc  = (state_q == S_IDLE) && ren && !wen;
  end

  // Input synchroniser chain and edge detection against last cycle's synchronised value.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    in_w   = sync_q[SYNC_STAGES-1];
    prev_d = in_w;
    rise_w = in_w & ~prev_q;
    fall_w = ~in_w & prev_q;
    evt_w  = (rise_w & rise_en_q) | (fall_w & fall_en_q);
  end

  // Register writes, including atomic set/clear/toggle and W1C on the status register.
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_w     = '0;
    if (wr_acc) begin
      case (reg_sel)
        R_OUT:      out_d     = wdata;
        R_OE:       oe_d      = wdata;
        R_SET:      out_d     = out_q | wdata;
        R_CLR:      out_d     = out_q & ~wdata;
        R_TGL:      out_d     = out_q ^ wdata;
        R_RISE_EN:  rise_en_d = wdata;
        R_FALL_EN:  fall_en_d = wdata;
        R_IRQ_STAT: w1c_w     = wdata;
        default:    ;
      endcase
    end
    // Capture is OR-ed in after the clear so a same-cycle event keeps its bit set.
    irq_stat_d = (irq_stat_q & ~w1c_w) | evt_w;
  end

  // Read mux over pre-edge register state; unmapped and write-only offsets read 0.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      R_OUT:      rd_word[WIDTH-1:0] = out_q;
      R_OE:       rd_word[WIDTH-1:0] = oe_q;
      R_IN:       rd_word[WIDTH-1:0] = in_w;
      R_RISE_EN:  rd_word[WIDTH-1:0] = rise_en_q;
      R_FALL_EN:  rd_word[WIDTH-1:0] = fall_en_q;
      R_IRQ_STAT: rd_word[WIDTH-1:0] = irq_stat_q;
      default:    ;
    endcase
  end

  // Bus handshake: accept in IDLE, one-cycle ready in ACK, wait for request release.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (wen || ren) begin
          state_d = S_ACK;
          ready_d = 1'b1;
          if (rd_acc) begin
            rdata_d = rd_word;
          end
        end
      end
      S_ACK: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!wen && !ren) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      out_q      <= '0;
      oe_q       <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= prev_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign ready    = ready_q;
  assign data_out = rdata_q;
  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;
  assign irq      = |irq_stat_q;

endmodule

// File: tb/tb_pic_gpio_bank.sv
// Scoreboard bench for pic_gpio_bank with directed bus and pad stimulus.
module tb_pic_gpio_bank;

  localparam int unsigned W  = 16;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   address;
  logic [31:0]   data_in;
  logic          wen;
  logic          ren;
  logic [31:0]   data_out;
  logic          ready;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  pic_gpio_bank #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .wen      (wen),
    .ren      (ren),
    .data_out (data_out),
    .ready    (ready),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [3:0]  reg_i;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse consumes one expected access; reads compare data.
  always @(negedge clk) begin
    exp_t e;
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        if (e.is_rd) chk($sformatf("read_r%0d", e.reg_i), data_out, e.data);
      end
    end else begin
      chk("data_out_idle", data_out, 32'h0);
    end
  end

  // One bus access; request held for 'hold' extra cycles after ready.
  task automatic bus(input bit rd, input logic [3:0] r, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input int hold);
    exp_t e;
    bit   seen;
    e.is_rd = rd;
    e.data  = exp_rd;
    e.reg_i = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    address = {10'd0, r, 2'b00};
    data_in = wd;
    wen     = !rd;
    ren     = rd;
    seen    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL bus_timeout_r%0d actual=no_ready expected=ready", r);
    end
    repeat (hold) @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_ready(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no_ready expected=ready", nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset   = 1'b0;
    address = '0;
    data_in = '0;
    wen     = 1'b0;
    ren     = 1'b0;
    gpio_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ready", ready, 0);
    reset = 1'b1;

    // Reset values at every offset
    for (int i = 0; i < 16; i++) bus(1'b1, 4'(i), 32'h0, 32'h0, 0);

    // Data register and atomic operations, request held 5 cycles
    bus(1'b0, 4'd0, 32'h0000_00FF, 0, 5); chk("out_write", gpio_out, 16'h00FF);
    bus(1'b0, 4'd3, 32'h0000_0F00, 0, 5); chk("out_set",   gpio_out, 16'h0FFF);
    bus(1'b0, 4'd4, 32'h0000_000F, 0, 5); chk("out_clr",   gpio_out, 16'h0FF0);
    bus(1'b0, 4'd5, 32'h0000_FFFF, 0, 5); chk("out_tgl",   gpio_out, 16'hF00F);
    bus(1'b1, 4'd0, 0, 32'h0000_F00F, 0);
    bus(1'b1, 4'd3, 0, 32'h0, 0);
    bus(1'b1, 4'd5, 0, 32'h0, 0);
    bus(1'b0, 4'd1, 32'hFFFF_00FF, 0, 0); chk("oe_write", gpio_oe, 16'h00FF);
    bus(1'b1, 4'd1, 0, 32'h0000_00FF, 0);
    bus(1'b0, 4'd0, 32'hFFFF_FFFF, 0, 0);
    bus(1'b1, 4'd0, 0, 32'h0000_FFFF, 0);
    bus(1'b0, 4'd12, 32'h1234_5678, 0, 0);
    bus(1'b1, 4'd12, 0, 32'h0, 0);
    bus(1'b1, 4'd0, 0, 32'h0000_FFFF, 0);

    // Input synchroniser latency and read-only IN
    #1 gpio_in = 16'h0005;
    bus(1'b1, 4'd2, 0, 32'h0, 0);
    bus(1'b1, 4'd2, 0, 32'h0000_0005, 0);
    bus(1'b0, 4'd2, 32'hFFFF_FFFF, 0, 0);
    bus(1'b1, 4'd2, 0, 32'h0000_0005, 0);
    #1 gpio_in = 16'h0000;
    repeat (5) @(posedge clk);

    // Edge capture: pin0 rise, pin1 fall
    bus(1'b0, 4'd6, 32'h0000_0001, 0, 0);
    bus(1'b0, 4'd7, 32'h0000_0002, 0, 0);
    bus(1'b1, 4'd6, 0, 32'h0000_0001, 0);
    bus(1'b1, 4'd7, 0, 32'h0000_0002, 0);
    #1 gpio_in = 16'h0003;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); chk("irq_before_latency", irq, 0);
    @(negedge clk); chk("irq_at_latency", irq, 1);
    repeat (3) @(posedge clk);
    #1 gpio_in = 16'h0000;
    repeat (5) @(posedge clk);
    chk("irq_after_pulses", irq, 1);
    bus(1'b1, 4'd8, 0, 32'h0000_0003, 0);
    bus(1'b0, 4'd8, 32'h0000_0001, 0, 0);
    bus(1'b1, 4'd8, 0, 32'h0000_0002, 0);
    chk("irq_one_left", irq, 1);
    bus(1'b0, 4'd8, 32'h0000_0002, 0, 0);
    chk("irq_cleared", irq, 0);
    bus(1'b1, 4'd8, 0, 32'h0, 0);

    // Enabling rise detection on an already-high pin creates no event
    #1 gpio_in = 16'h0004;
    repeat (5) @(posedge clk);
    bus(1'b0, 4'd6, 32'h0000_0005, 0, 0);
    repeat (5) @(posedge clk);
    bus(1'b1, 4'd8, 0, 32'h0, 0);
    chk("irq_no_enable_event", irq, 0);
    #1 gpio_in = 16'h0000;
    repeat (5) @(posedge clk);
    bus(1'b1, 4'd8, 0, 32'h0, 0);

    // W1C of bit0 on the same edge that captures a pin0 rise
    #1 gpio_in = 16'h0001;
    @(posedge clk);
    bus(1'b0, 4'd8, 32'h0000_0001, 0, 0);
    bus(1'b1, 4'd8, 0, 32'h0000_0001, 0);
    chk("irq_event_beats_w1c", irq, 1);

    // Reset asserted in WAIT with a write held
    e.is_rd = 1'b0; e.data = 0; e.reg_i = 4'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    address = 16'h0000;
    data_in = 32'h0000_AAAA;
    wen     = 1'b1;
    wait_ready("rst_first_ready");
    chk("rst_pre_out", gpio_out, 16'hAAAA);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_gpio_out", gpio_out, 0);
    chk("rst_mid_gpio_oe", gpio_oe, 0);
    chk("rst_mid_irq", irq, 0);
    chk("rst_mid_ready", ready, 0);
    chk("rst_mid_data_out", data_out, 0);
    repeat (3) @(posedge clk);
    sb.push_back(e);
    #1 reset = 1'b1;
    wait_ready("rst_second_ready");
    chk("rst_reaccept_out", gpio_out, 16'hAAAA);
    repeat (4) @(posedge clk);
    #1 wen = 1'b0;
    @(posedge clk);
    chk("rst_post_oe", gpio_oe, 0);
    bus(1'b1, 4'd0, 0, 32'h0000_AAAA, 0);
    bus(1'b1, 4'd8, 0, 32'h0, 0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_gpio_bank.md
# pic_gpio_bank

Parametrised GPIO peripheral for the PIC wrapper's memory-mapped bus. It replaces the fixed 16-bit gpio_in/gpio_out pair with a WIDTH-bit bank that adds:
- per-pin output enable;
- atomic set/clear/toggle;
- synchronised inputs;
- per-pin rising/falling edge interrupt capture with a single irq line.

It sits between the PIC/SoC bus (address, data_in, wen, ren, data_out, ready) and the pads.

## Interface
- WIDTH, 16, number of GPIO pins (1..32); register bits above WIDTH-1 read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (≥2)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset; all registers cleared while low
- address  in  16  byte address; address[5:2] selects register, other bits ignored
- data_in  in  32  write data
- wen  in  1  write request, held until ready seen
- ren  in  1  read request, held until ready seen
- data_out  out  32  read data, valid only while ready=1, else 0
- ready  out  1  one-cycle access acknowledge
- gpio_in  in  WIDTH  asynchronous pad inputs
- gpio_out  out  WIDTH  output data register
- gpio_oe  out  WIDTH  per-pin output enable (1 = drive)
- irq  out  1  OR of IRQ_STAT bits

## Operation
- Register map (address[5:2]):
  - 0 OUT rw
  - 1 OE rw
  - 2 IN ro (synchronised pins)
  - 3 SET wo: OUT |= data
  - 4 CLR wo: OUT &= ~data
  - 5 TGL wo: OUT ^= data
  - 6 RISE_EN rw
  - 7 FALL_EN rw
  - 8 IRQ_STAT rw1c
  - 9..15 unmapped: read 0, writes ignored
- Write-only registers (SET/CLR/TGL) read 0. Writes to IN are ignored.
- Bus FSM, three states:
  - IDLE: on (wen|ren), go to ACK and perform the access at that edge. wen has priority if both are high; ren is then ignored for this access.
  - ACK: ready=1 for exactly one cycle, then go to WAIT.
  - WAIT: stay until wen=0 and ren=0, then go to IDLE. One request yields exactly one access.
- Input path: SYNC_STAGES flops per pin feed IN; a further prev register holds last cycle's IN.
  - rise[i] = IN[i] & ~prev[i]
  - fall[i] = ~IN[i] & prev[i]
- Event capture: IRQ_STAT[i] is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Writing 1 to an IRQ_STAT bit clears it; writing 0 has no effect.
- Simultaneous event and W1C on the same bit: the event wins, and the bit stays 1.
- Enabling RISE_EN while a pin is already high creates no event.
- irq is combinational |IRQ_STAT. Masking via *_EN affects only future captures; bits already set remain set.
- Reset: OUT, OE, RISE_EN, FALL_EN, IRQ_STAT, synchronisers and prev clear to 0. The FSM goes to IDLE.
  - Outputs during and after reset: gpio_out=0, gpio_oe=0, irq=0, ready=0, data_out=0.
  - Reset asserted mid-access aborts the access. After release, a still-held request is accepted as new.

## Timing
- Access accepted at edge T, the first edge in IDLE with wen|ren high.
- Write: register updates at T; gpio_out/gpio_oe change immediately after T.
- Read: data captured at T; ready=1 and data_out valid in cycle T..T+1.
- ready deasserts at T+1. The earliest next acceptance is the edge after the master drops its request.
- Pin change to IN visibility: SYNC_STAGES cycles.
- Pin edge to IRQ_STAT/irq: SYNC_STAGES+1 cycles.
- IRQ_STAT read at T reflects state before that edge's capture.

## Test plan
- Reset then read all 16 addresses:
  - OUT/OE/RISE_EN/FALL_EN/IRQ_STAT/unmapped read 0x00000000;
  - gpio_out=0, gpio_oe=0, irq=0.
- Write OUT=0x00FF, SET 0x0F00, CLR 0x000F, TGL 0xFFFF:
  - gpio_out sequence 0x00FF, 0x0FFF, 0x0FF0, 0xF00F;
  - read OUT returns 0x0000F00F;
  - each access gives exactly one ready pulse even with wen held 5 cycles.
- Drive gpio_in=0x0005:
  - IN reads 0x0005 no earlier than SYNC_STAGES cycles later;
  - write 0xFFFFFFFF to IN leaves it unchanged.
- RISE_EN=0x0001, FALL_EN=0x0002; pulse pin0 high, pin1 low→high→low:
  - IRQ_STAT=0x0003 and irq=1;
  - W1C 0x0001 leaves 0x0002;
  - W1C 0x0002 gives irq=0.
- W1C of bit0 issued in the same cycle a rising edge on pin0 is captured: IRQ_STAT[0] remains 1.
- Assert reset (low) during the WAIT state with wen held and OUT=0xAAAA:
  - all outputs go 0 immediately;
  - after release, the held write is performed once with one ready pulse.
